// File: rtl/id_pipe.sv
// Instruction-decode stage: combinational decode and operand selection with
// EX/MEM forwarding, feeding a single valid/ready output register.
module id_pipe #(
    parameter bit FWD_EN  = 1'b1,
    parameter int PC_W    = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     data_i,
    input  logic            flush_i,
    output logic            reg1_read_o,
    output logic            reg2_read_o,
    output logic [4:0]      reg1_addr_o,
    output logic [4:0]      reg2_addr_o,
    input  logic [31:0]     reg1_data_i,
    input  logic [31:0]     reg2_data_i,
    input  logic            ex_wreg_i,
    input  logic [4:0]      ex_waddr_i,
    input  logic [31:0]     ex_wdata_i,
    input  logic            mem_wreg_i,
    input  logic [4:0]      mem_waddr_i,
    input  logic [31:0]     mem_wdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic [7:0]      aluop_o,
    output logic [2:0]      alusel_o,
    output logic [31:0]     reg1_data_o,
    output logic [31:0]     reg2_data_o,
    output logic            wreg_o,
    output logic [4:0]      waddr_o,
    output logic            ill_o
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef enum logic [2:0] {
        SEL_LOGIC = 3'b000,
        SEL_SHIFT = 3'b001,
        SEL_ARITH = 3'b010
    } alusel_e;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_sa;
    logic [15:0] w_imm;
    logic        w_legal, w_read1, w_read2, w_wreg, w_capture;
    logic [31:0] w_alt1, w_alt2, w_opnd1, w_opnd2;
    logic [4:0]  w_waddr;
    logic [7:0]  w_aluop;
    alusel_e     w_alusel;

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_aluop;
    logic [2:0]      r_alusel;
    logic [31:0]     r_reg1, r_reg2;
    logic            r_wreg;
    logic [4:0]      r_waddr;
    logic            r_ill;

    assign w_op    = data_i[31:26];
    assign w_rs    = data_i[25:21];
    assign w_rt    = data_i[20:16];
    assign w_rd    = data_i[15:11];
    assign w_sa    = data_i[10:6];
    assign w_funct = data_i[5:0];
    assign w_imm   = data_i[15:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_legal  = 1'b0;
        w_read1  = 1'b0;
        w_read2  = 1'b0;
        w_alt1   = '0;
        w_alt2   = '0;
        w_waddr  = '0;
        w_aluop  = '0;
        w_alusel = SEL_LOGIC;
        case (w_op)
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDIU, OP_LUI: begin
                w_legal = 1'b1;
                w_read1 = 1'b1;
                w_waddr = w_rt;
                w_aluop = {2'b00, w_op};
                case (w_op)
                    OP_ADDIU: begin
                        w_alt2   = {{16{w_imm[15]}}, w_imm};
                        w_alusel = SEL_ARITH;
                    end
                    OP_LUI:  w_alt2 = {w_imm, 16'h0000};
                    default: w_alt2 = {16'h0000, w_imm};
                endcase
            end
            OP_SPECIAL: begin
                case (w_funct)
                    FN_AND, FN_OR, FN_XOR: begin
                        w_legal = 1'b1;
                        w_read1 = 1'b1;
                        w_read2 = 1'b1;
                    end
                    FN_ADDU, FN_SUBU: begin
                        w_legal  = 1'b1;
                        w_read1  = 1'b1;
                        w_read2  = 1'b1;
                        w_alusel = SEL_ARITH;
                    end
                    FN_SLL: begin
                        w_legal  = 1'b1;
                        w_read2  = 1'b1;
                        w_alt1   = {27'h0, w_sa};
                        w_alusel = SEL_SHIFT;
                    end
                    default: ;
                endcase
                if (w_legal) begin
                    w_waddr = w_rd;
                    w_aluop = {2'b01, w_funct};
                end
            end
            default: ;
        endcase
    end

    // Register 0 beats EX, which beats MEM, which beats the regfile.
    function automatic logic [31:0] pick_operand(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        ex_we,
        input logic [4:0]  ex_addr,
        input logic [31:0] ex_data,
        input logic        mem_we,
        input logic [4:0]  mem_addr,
        input logic [31:0] mem_data
    );
        if (ZERO_R0 && addr == 5'd0)
            pick_operand = '0;
        else if (FWD_EN && ex_we && ex_addr == addr)
            pick_operand = ex_data;
        else if (FWD_EN && mem_we && mem_addr == addr)
            pick_operand = mem_data;
        else
            pick_operand = rf_data;
    endfunction

    assign w_opnd1 = w_read1 ? pick_operand(w_rs, reg1_data_i, ex_wreg_i, ex_waddr_i, ex_wdata_i,
                                            mem_wreg_i, mem_waddr_i, mem_wdata_i) : w_alt1;
    assign w_opnd2 = w_read2 ? pick_operand(w_rt, reg2_data_i, ex_wreg_i, ex_waddr_i, ex_wdata_i,
                                            mem_wreg_i, mem_waddr_i, mem_wdata_i) : w_alt2;
    assign w_wreg  = w_legal && (w_waddr != 5'd0);

    assign reg1_read_o = w_read1;
    assign reg2_read_o = w_read2;
    assign reg1_addr_o = w_read1 ? w_rs : 5'd0;
    assign reg2_addr_o = w_read2 ? w_rt : 5'd0;

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_capture  = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_aluop  <= '0;
            r_alusel <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_wreg   <= 1'b0;
            r_waddr  <= '0;
            r_ill    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (flush_i)
                r_valid <= 1'b0;
            else if (w_capture)
                r_valid <= 1'b1;
            else if (out_ready_i)
                r_valid <= 1'b0;

            if (w_capture) begin
                r_pc     <= pc_i;
                r_aluop  <= w_aluop;
                r_alusel <= w_alusel;
                r_reg1   <= w_opnd1;
                r_reg2   <= w_opnd2;
                r_wreg   <= w_wreg;
                r_waddr  <= w_waddr;
                r_ill    <= !w_legal;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign pc_o        = r_pc;
    assign aluop_o     = r_aluop;
    assign alusel_o    = r_alusel;
    assign reg1_data_o = r_reg1;
    assign reg2_data_o = r_reg2;
    assign wreg_o      = r_wreg;
    assign waddr_o     = r_waddr;
    assign ill_o       = r_ill;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed scenarios then randomized traffic, checked against
// a mnemonic-level decode model and a one-entry output-register model.
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid_i, flush_i, out_ready_i;
    logic [31:0] pc_i, data_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, mem_wreg_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;

    logic        in_ready_o, reg1_read_o, reg2_read_o, out_valid_o, wreg_o, ill_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, waddr_o;
    logic [31:0] pc_o, reg1_data_o, reg2_data_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;

    logic        nf_in_ready, nf_rd1, nf_rd2, nf_valid, nf_wreg, nf_ill;
    logic [4:0]  nf_a1, nf_a2, nf_waddr;
    logic [31:0] nf_pc, nf_reg1, nf_reg2;
    logic [7:0]  nf_aluop;
    logic [2:0]  nf_alusel;

    always #5 clk = ~clk;

    id_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .data_i(data_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
        .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
        .wreg_o(wreg_o), .waddr_o(waddr_o), .ill_o(ill_o)
    );

    id_pipe #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(nf_in_ready),
        .pc_i(pc_i), .data_i(data_i), .flush_i(flush_i),
        .reg1_read_o(nf_rd1), .reg2_read_o(nf_rd2),
        .reg1_addr_o(nf_a1), .reg2_addr_o(nf_a2),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(nf_valid), .out_ready_i(out_ready_i), .pc_o(nf_pc),
        .aluop_o(nf_aluop), .alusel_o(nf_alusel),
        .reg1_data_o(nf_reg1), .reg2_data_o(nf_reg2),
        .wreg_o(nf_wreg), .waddr_o(nf_waddr), .ill_o(nf_ill)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        wreg;
        logic [4:0]  waddr;
        logic        ill;
        logic        rd1;
        logic        rd2;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } dec_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    dec_t m, m_nf;
    logic m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Register value as the stage should see it: r0 is zero, newest producer wins.
    function automatic logic [31:0] src(input logic [4:0] r, input logic [31:0] rf, input bit fwd);
        if (r == 5'd0) return 32'h0;
        if (fwd && ex_wreg_i && ex_waddr_i == r) return ex_wdata_i;
        if (fwd && mem_wreg_i && mem_waddr_i == r) return mem_wdata_i;
        return rf;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w, input bit fwd);
        dec_t d;
        logic [5:0]  op    = w[31:26];
        logic [4:0]  rs    = w[25:21];
        logic [4:0]  rt    = w[20:16];
        logic [4:0]  rd    = w[15:11];
        logic [4:0]  sa    = w[10:6];
        logic [5:0]  funct = w[5:0];
        logic [15:0] imm   = w[15:0];
        d    = '0;
        d.pc = pc_i;
        if (op == 6'h00 && funct inside {6'h24, 6'h25, 6'h26, 6'h21, 6'h23}) begin
            d.rd1 = 1; d.rd2 = 1; d.a1 = rs; d.a2 = rt;
            d.r1 = src(rs, reg1_data_i, fwd);
            d.r2 = src(rt, reg2_data_i, fwd);
            d.waddr = rd;
            d.aluop = {2'b01, funct};
            d.alusel = (funct inside {6'h21, 6'h23}) ? 3'b010 : 3'b000;
        end else if (op == 6'h00 && funct == 6'h00) begin
            d.rd2 = 1; d.a2 = rt;
            d.r1 = 32'(sa);
            d.r2 = src(rt, reg2_data_i, fwd);
            d.waddr = rd;
            d.aluop = 8'h40;
            d.alusel = 3'b001;
        end else if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h0F}) begin
            d.rd1 = 1; d.a1 = rs;
            d.r1 = src(rs, reg1_data_i, fwd);
            d.waddr = rt;
            d.aluop = 8'(op);
            if (op == 6'h09) begin
                d.r2 = 32'(signed'(imm));
                d.alusel = 3'b010;
            end else if (op == 6'h0F) begin
                d.r2 = 32'(imm) << 16;
            end else begin
                d.r2 = 32'(imm);
            end
        end else begin
            d.ill = 1;
        end
        d.wreg = !d.ill && d.waddr != 5'd0;
        return d;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid_o), 32'(m_valid));
        check("pc", pc_o, m.pc);
        check("aluop", 32'(aluop_o), 32'(m.aluop));
        check("alusel", 32'(alusel_o), 32'(m.alusel));
        check("reg1_data", reg1_data_o, m.r1);
        check("reg2_data", reg2_data_o, m.r2);
        check("wreg", 32'(wreg_o), 32'(m.wreg));
        check("waddr", 32'(waddr_o), 32'(m.waddr));
        check("ill", 32'(ill_o), 32'(m.ill));
        check("nofwd_reg1", nf_reg1, m_nf.r1);
        check("nofwd_reg2", nf_reg2, m_nf.r2);
    endtask

    // Drive one cycle of inputs, check the combinational side, then the registered side.
    task automatic step(input logic [31:0] w, input logic [31:0] pc,
                        input logic v, input logic rdy, input logic fl);
        dec_t d, dn;
        logic cap;
        data_i = w; pc_i = pc; in_valid_i = v; out_ready_i = rdy; flush_i = fl;
        #1;
        check("in_ready", 32'(in_ready_o), 32'(!m_valid || rdy));
        d  = ref_decode(w, 1'b1);
        dn = ref_decode(w, 1'b0);
        check("reg1_read", 32'(reg1_read_o), 32'(d.rd1));
        check("reg2_read", 32'(reg2_read_o), 32'(d.rd2));
        if (d.rd1) check("reg1_addr", 32'(reg1_addr_o), 32'(d.a1));
        if (d.rd2) check("reg2_addr", 32'(reg2_addr_o), 32'(d.a2));
        cap = v && (!m_valid || rdy) && !fl;
        if (fl)       m_valid = 1'b0;
        else if (cap) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
        if (cap) begin
            m    = d;
            m_nf = dn;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        m = '0; m_nf = '0; m_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready_o), 32'h1);
        check_outputs();
        #1 reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [5:0] iops [5]  = '{6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h0F};
        logic [5:0] fns  [6]  = '{6'h24, 6'h25, 6'h26, 6'h21, 6'h23, 6'h00};
        logic [4:0] a = 5'($urandom_range(0, 3));
        logic [4:0] b = 5'($urandom_range(0, 3));
        logic [4:0] c = 5'($urandom_range(0, 3));
        int k = $urandom_range(0, 11);
        if (k < 5)  return {iops[k], a, b, 16'($urandom)};
        if (k < 11) return {6'h00, a, b, c, 5'($urandom), fns[k-5]};
        return $urandom;
    endfunction

    task automatic rand_operands();
        reg1_data_i = $urandom; reg2_data_i = $urandom;
        ex_wreg_i   = 1'($urandom); ex_waddr_i  = 5'($urandom_range(0, 3)); ex_wdata_i  = $urandom;
        mem_wreg_i  = 1'($urandom); mem_waddr_i = 5'($urandom_range(0, 3)); mem_wdata_i = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        in_valid_i = 0; flush_i = 0; out_ready_i = 0; pc_i = 0; data_i = 0;
        reg1_data_i = 0; reg2_data_i = 0;
        ex_wreg_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        mem_wreg_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
        m = '0; m_nf = '0; m_valid = 1'b0;

        // Reset state
        #12;
        check("reset_in_ready", 32'(in_ready_o), 32'h1);
        check_outputs();
        #1 reset_n = 1'b1;

        // ORI r3,r1,0x8001 without forwarding
        reg1_data_i = 32'h1234_0000;
        step(32'h3423_8001, 32'h100, 1, 1, 0);
        check("ori_aluop", 32'(aluop_o), 32'h0D);
        check("ori_reg2", reg2_data_o, 32'h0000_8001);
        check("ori_waddr", 32'(waddr_o), 32'd3);

        // ADDIU r2,r0,-1 then ADDU r4,r2,r2 with EX and MEM both targeting r2
        reg1_data_i = 32'h1357_9BDF; reg2_data_i = 32'h1357_9BDF;
        ex_wreg_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'hFFFF_FFFF;
        mem_wreg_i = 1; mem_waddr_i = 2; mem_wdata_i = 32'h5;
        step(32'h2402_FFFF, 32'h104, 1, 1, 0);
        check("addiu_reg2", reg2_data_o, 32'hFFFF_FFFF);
        step(32'h0042_2021, 32'h108, 1, 1, 0);
        check("addu_fwd_reg1", reg1_data_o, 32'hFFFF_FFFF);
        check("addu_nofwd_reg1", nf_reg1, 32'h1357_9BDF);

        // Three-cycle stall with a new instruction waiting, then release
        for (int i = 0; i < 3; i++) begin
            rand_operands();
            step(rand_word(), 32'h200 + 32'(i), 1, 0, 0);
        end
        rand_operands();
        step(32'h3423_0007, 32'h300, 1, 1, 0);
        step(32'h0, 32'h304, 0, 1, 0);

        // Flush against a held instruction and a new one, then normal acceptance
        step(32'h3423_0009, 32'h400, 1, 0, 0);
        step(32'h3423_000A, 32'h404, 1, 0, 1);
        step(32'h3423_000B, 32'h408, 1, 1, 0);

        // Illegal opcode, illegal funct, all-zero NOP
        step(32'hFC00_0000, 32'h500, 1, 1, 0);
        check("ill_op_ill", 32'(ill_o), 32'h1);
        step(32'h0000_003F, 32'h504, 1, 1, 0);
        check("ill_fn_aluop", 32'(aluop_o), 32'h0);
        step(32'h0000_0000, 32'h508, 1, 1, 0);
        check("nop_alusel", 32'(alusel_o), 32'h1);

        // Asynchronous reset while an instruction is held
        step(32'h3423_0011, 32'h600, 1, 0, 0);
        pulse_reset();
        step(32'h3423_0012, 32'h604, 1, 0, 0);
        step(32'h3423_0013, 32'h608, 1, 0, 0);
        pulse_reset();
        step(32'h3423_0014, 32'h60C, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_operands();
            step(rand_word(), $urandom,
                 1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameters SHALL be: FWD_EN, 1, enable EX/MEM operand forwarding (0 = regfile data only); PC_W, 32, program-counter width; ZERO_R0, 1, register 0 operand reads as 0 regardless of source.
REQ-002 Ports SHALL be, in order: clk in 1 clock; reset_n in 1 asynchronous active-low reset; in_valid_i in 1 instruction valid; in_ready_o out 1 stage can accept; pc_i in PC_W; data_i in 32 instruction word; flush_i in 1 discard held/incoming instruction; reg1_read_o/reg2_read_o out 1 and reg1_addr_o/reg2_addr_o out 5 combinational regfile read requests; reg1_data_i/reg2_data_i in 32 regfile read data; ex_wreg_i in 1, ex_waddr_i in 5, ex_wdata_i in 32 EX result; mem_wreg_i in 1, mem_waddr_i in 5, mem_wdata_i in 32 MEM result; out_valid_o out 1; out_ready_i in 1; pc_o out PC_W; aluop_o out 8; alusel_o out 3; reg1_data_o/reg2_data_o out 32; wreg_o out 1; waddr_o out 5; ill_o out 1 illegal instruction.
REQ-003 One clock domain (clk); reset_n asynchronous assert, active low; all output-register fields cleared while reset_n is low.

Function
REQ-004 Decode SHALL be combinational from data_i; op=data_i[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0].
REQ-005 I-type set: ANDI 0x0C, ORI 0x0D, XORI 0x0E (zero-ext imm), ADDIU 0x09 (sign-ext imm), LUI 0x0F (imm<<16); reg1=rs read, reg2 not read, operand2=extended imm, waddr=rt, aluop={2'b00,op}.
REQ-006 R-type (op=0) set: AND 0x24, OR 0x25, XOR 0x26, ADDU 0x21, SUBU 0x23 (reg1=rs, reg2=rt, waddr=rd); SLL 0x00 (reg1 not read, operand1=zero-ext sa, reg2=rt, waddr=rd); aluop={2'b01,funct}.
REQ-007 alusel: 3'b000 logic (AND/OR/XOR/ANDI/ORI/XORI/LUI), 3'b001 shift (SLL), 3'b010 arith (ADDU/SUBU/ADDIU).
REQ-008 Any other op/funct SHALL be illegal: ill=1, wreg=0, aluop=0, alusel=0, reg1_read=reg2_read=0, operands 0.
REQ-009 wreg SHALL be 1 for every legal instruction except when waddr=0, then 0 (all-zero word = SLL $0 → legal NOP, wreg 0).
REQ-010 Operand select per read port, priority high→low: ZERO_R0 and addr=0 → 0; FWD_EN and ex_wreg_i and ex_waddr_i=addr → ex_wdata_i; FWD_EN and mem_wreg_i and mem_waddr_i=addr → mem_wdata_i; else regfile data. Unread port uses immediate/sa per REQ-005/006.
REQ-011 in_ready_o = !out_valid_o || out_ready_i (combinational, independent of flush_i).
REQ-012 Capture: on clk rising edge with in_valid_i && in_ready_o && !flush_i, output register loads pc, decode fields and selected operands; out_valid_o←1.
REQ-013 Drain: out_ready_i && out_valid_o with no capture → out_valid_o←0; output fields hold last values.
REQ-014 Stall: out_valid_o && !out_ready_i → all output fields held unchanged; forwarding inputs ignored until re-capture.
REQ-015 flush_i=1 → out_valid_o←0 next edge, incoming instruction dropped, fields hold; flush wins over simultaneous capture and stall.
REQ-016 Latency: exactly one cycle from accepted input to out_valid_o; full throughput (one per cycle) when out_ready_i held 1.
REQ-017 ill_o, wreg_o, waddr_o SHALL be qualified only by out_valid_o; downstream ignores them when out_valid_o=0.

Reset
REQ-018 Reset values: out_valid_o=0, pc_o=0, aluop_o=0, alusel_o=0, reg1_data_o=0, reg2_data_o=0, wreg_o=0, waddr_o=0, ill_o=0.
REQ-019 reset_n low mid-stall SHALL discard the held instruction; first edge after release with in_valid_i accepts new instruction (in_ready_o=1 out of reset).

Verification
REQ-020 ORI r3,r1,0x8001 (0x34238001), reg1_data_i=0x12340000, no forwarding → next cycle out_valid=1, aluop=0x0D, alusel=000, reg1=0x12340000, reg2=0x00008001, wreg=1, waddr=3.
REQ-021 ADDIU r2,r0,0xFFFF then ADDU r4,r2,r2 with ex_wreg=1/ex_waddr=2/ex_wdata=0xFFFFFFFF, mem_waddr=2/mem_wdata=5 → ADDIU reg2=0xFFFFFFFF; ADDU reg1=reg2=0xFFFFFFFF (EX over MEM); with FWD_EN=0 both = reg2_data_i.
REQ-022 out_ready_i=0 for 3 cycles with in_valid_i=1 → in_ready_o=0, outputs frozen; out_ready_i=1 → next instruction captured same edge, no loss or duplication.
REQ-023 flush_i=1 coincident with in_valid_i=1 and held instruction → out_valid=0 next cycle; following instruction accepted normally.
REQ-024 op=0x3F and R-type funct=0x3F → ill=1, wreg=0, aluop=0; all-zero word → ill=0, wreg=0, alusel=001.
REQ-025 reset_n pulsed low asynchronously between edges while out_valid=1 → all outputs REQ-018 values immediately, in_ready_o=1.
